// File: rtl/mult_share_sched_pkg.sv
// Shared definitions for the multiplier-sharing scheduler: width helper and
// the {valid, id} tag that travels alongside each product through the
// multiplier latency.
package mult_share_sched_pkg;

    // Widest requester id a tag can carry (supports up to 256 requesters).
    localparam int TAG_ID_W = 8;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Tag accompanying an operand pair through the shared multiplier.
    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/mult_share_sched_if.sv
// Requester/response bundle of the scheduler.
//
// Handshake: req_valid[i] means requester i presents a stable operand pair on
// its req_a/req_b slice; req_ready[i] is the grant. A pair transfers on a
// rising clk edge where req_valid[i] and req_ready[i] are both high. A
// requester must hold valid and operands until it sees that edge. Responses
// have no backpressure: rsp_valid is a one-cycle pulse qualifying rsp_id and
// rsp_o, one pulse per transferred pair, in acceptance order.
interface mult_share_sched_if
    import mult_share_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH_A = 16,
    parameter int WIDTH_B = 13,
    parameter int WIDTH_O = WIDTH_A + WIDTH_B,
    parameter int ID_W    = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ)
);

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*WIDTH_A-1:0] req_a;
    logic [NUM_REQ*WIDTH_B-1:0] req_b;
    logic                       rsp_valid;
    logic [ID_W-1:0]            rsp_id;
    logic [WIDTH_O-1:0]         rsp_o;

    // Requester side.
    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_id, rsp_o
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_id, rsp_o
    );

endinterface

// File: rtl/mult_share_sched_rr_arbiter.sv
// Round-robin arbiter: starting at ptr and wrapping, grants the first
// asserted request. Purely combinational; the caller owns the pointer.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    // Walk from ptr in wrap-around order and latch the first hit.
    always_comb begin
        int   idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mult_share_sched.sv
// Time-shares one external signed multiplier among NUM_REQ requesters.
// Grants one operand pair per cycle round-robin, registers it onto the
// multiplier inputs, and carries the requester id through a tag pipeline
// matching the multiplier latency so each product comes back labelled.
module mult_share_sched
    import mult_share_sched_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int WIDTH_A      = 16,
    parameter int WIDTH_B      = 13,
    parameter int WIDTH_O      = WIDTH_A + WIDTH_B,
    parameter int MULT_LATENCY = 4,
    parameter int ID_W         = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               arst,
    mult_share_sched_if.slave  bus,
    output logic [WIDTH_A-1:0] mult_a,
    output logic [WIDTH_B-1:0] mult_b,
    input  logic [WIDTH_O-1:0] mult_o
);

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               xfer;

    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [WIDTH_A-1:0] mult_a_q, mult_a_d;
    logic [WIDTH_B-1:0] mult_b_q, mult_b_d;
    tag_t               tag_q [MULT_LATENCY];
    tag_t               tag_d [MULT_LATENCY];
    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req       (bus.req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // The grant is the ready; a grant only exists where valid is high, so
    // any grant bit set is a transfer on the coming edge.
    assign bus.req_ready = grant;
    assign xfer          = |grant;

    // Next-state: pointer advance, operand capture, tag shift, response regs.
    always_comb begin
        ptr_d       = ptr_q;
        mult_a_d    = mult_a_q;
        mult_b_d    = mult_b_q;
        rsp_valid_d = tag_q[MULT_LATENCY-1].valid;
        rsp_id_d    = tag_q[MULT_LATENCY-1].id[ID_W-1:0];

        if (xfer) begin
            ptr_d    = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            mult_a_d = bus.req_a[grant_idx*WIDTH_A +: WIDTH_A];
            mult_b_d = bus.req_b[grant_idx*WIDTH_B +: WIDTH_B];
        end

        // Stage 0 records every cycle; bubbles are simply valid=0 tags.
        tag_d[0].valid = xfer;
        tag_d[0].id    = TAG_ID_W'(grant_idx);
        for (int i = 1; i < MULT_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // State registers; reset drops every in-flight tag.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ptr_q       <= '0;
            mult_a_q    <= '0;
            mult_b_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            for (int i = 0; i < MULT_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            mult_a_q    <= mult_a_d;
            mult_b_q    <= mult_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            for (int i = 0; i < MULT_LATENCY; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign mult_a        = mult_a_q;
    assign mult_b        = mult_b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_o     = mult_o;

endmodule

// File: tb/tb_mult_share_sched.sv
// Bench for mult_share_sched: external multiplier model, round-robin
// reference model with per-requester pending operands, scoreboard queue of
// expected {id, product, arrival cycle}, and a decoupled response monitor.
module tb_mult_share_sched;

    localparam int N   = 4;
    localparam int WA  = 16;
    localparam int WB  = 13;
    localparam int WO  = WA + WB;
    localparam int LAT = 4;
    localparam int IDW = 2;

    logic clk;
    logic arst;
    logic [WA-1:0] mult_a;
    logic [WB-1:0] mult_b;
    logic [WO-1:0] mult_o;

    mult_share_sched_if #(
        .NUM_REQ(N), .WIDTH_A(WA), .WIDTH_B(WB), .WIDTH_O(WO), .ID_W(IDW)
    ) bus ();

    mult_share_sched #(
        .NUM_REQ(N), .WIDTH_A(WA), .WIDTH_B(WB), .WIDTH_O(WO),
        .MULT_LATENCY(LAT), .ID_W(IDW)
    ) dut (
        .clk    (clk),
        .arst   (arst),
        .bus    (bus),
        .mult_a (mult_a),
        .mult_b (mult_b),
        .mult_o (mult_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // ---------------- external multiplier: LAT cycles after input regs ----
    logic signed [WO-1:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= $signed(mult_a) * $signed(mult_b);
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mult_o = mpipe[LAT-1];

    // ---------------- scoreboard ----------------
    logic [IDW+WO-1:0] exp_q[$];
    int                exp_cyc_q[$];
    int                n_tests = 0;
    int                n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // ---------------- reference model ----------------
    logic          pend_v [N];
    logic [WA-1:0] pend_a [N];
    logic [WB-1:0] pend_b [N];
    int            ptr_m;

    // Winner is the valid requester at the smallest forward distance from ptr.
    function automatic int model_grant();
        int best, bestd, d;
        best  = -1;
        bestd = N;
        for (int i = 0; i < N; i++) begin
            if (pend_v[i]) begin
                d = (i - ptr_m + N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    task automatic set_req(input int i, input logic [WA-1:0] a, input logic [WB-1:0] b);
        pend_v[i] = 1'b1;
        pend_a[i] = a;
        pend_b[i] = b;
    endtask

    // ---------------- driver: one clock cycle of stimulus ----------------
    task automatic step();
        int g;
        logic [N-1:0] exp_ready;
        logic signed [WO-1:0] p;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]          = pend_v[i];
            bus.req_a[i*WA +: WA]     = pend_a[i];
            bus.req_b[i*WB +: WB]     = pend_b[i];
        end
        #1;
        g = model_grant();
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        if (g >= 0) begin
            p = $signed(pend_a[g]) * $signed(pend_b[g]);
            exp_q.push_back({IDW'(g), p});
            exp_cyc_q.push_back(cycle + 1 + LAT);
        end
        @(posedge clk);
        if (g >= 0) begin
            ptr_m     = (g + 1) % N;
            pend_v[g] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst = 1'b1;
        exp_q.delete();
        exp_cyc_q.delete();
        ptr_m = 0;
        for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
        bus.req_valid = '1;
        #1;
        check("rst_mult_a", 64'(mult_a), 64'd0);
        check("rst_mult_b", 64'(mult_b), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        check("rst_ready_ptr0", 64'(bus.req_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        bus.req_valid = '0;
        arst = 1'b0;
    endtask

    function automatic logic [WA-1:0] rand_a();
        case ($urandom_range(0, 7))
            0:       return 16'h8000;
            1:       return 16'h7fff;
            default: return WA'($urandom);
        endcase
    endfunction

    function automatic logic [WB-1:0] rand_b();
        case ($urandom_range(0, 7))
            0:       return 13'h1000;
            1:       return 13'h0fff;
            default: return WB'($urandom);
        endcase
    endfunction

    // ---------------- monitor ----------------
    logic [IDW+WO-1:0] e;
    int                ec;
    always @(negedge clk) begin
        if (!arst) begin
            if (bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
                end else begin
                    e  = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    check("rsp_id", 64'(bus.rsp_id), 64'(e[IDW+WO-1:WO]));
                    check("rsp_o", 64'(bus.rsp_o), 64'(e[WO-1:0]));
                    check("rsp_cycle", 64'(cycle), 64'(ec));
                end
            end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cycle) begin
                check("rsp_missing", 64'(bus.rsp_valid), 64'd1);
                void'(exp_q.pop_front());
                void'(exp_cyc_q.pop_front());
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        arst          = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        ptr_m         = 0;
        for (int i = 0; i < N; i++) begin
            pend_v[i] = 1'b0;
            pend_a[i] = '0;
            pend_b[i] = '0;
        end
        do_reset();

        // Single request from requester 2 on the first edge after reset.
        set_req(2, -16'sd3, 13'sd5);
        step();
        repeat (LAT + 2) step();

        // All four valid continuously: grants rotate 0,1,2,3,0,...
        for (int s = 0; s < 10; s++) begin
            for (int i = 0; i < N; i++) if (!pend_v[i]) set_req(i, rand_a(), rand_b());
            step();
        end
        for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
        repeat (LAT + 2) step();

        // Move ptr to 2 via requester 1, then 1 and 3 compete: 3 first.
        do_reset();
        set_req(1, 16'd7, 13'd9);
        step();
        set_req(1, 16'd11, 13'd13);
        set_req(3, 16'hfff0, 13'd3);
        repeat (3) step();

        // Corner operands.
        set_req(0, 16'h8000, 13'h1000);
        step();
        set_req(0, 16'h7fff, 13'h1000);
        step();
        repeat (LAT + 2) step();

        // Reset with three transfers in flight: none may come back.
        set_req(0, 16'd1, 13'd1);
        set_req(1, 16'd2, 13'd2);
        set_req(2, 16'd3, 13'd3);
        repeat (4) step();
        do_reset();
        repeat (LAT + 3) step();
        // ptr back at 0 after reset.
        for (int i = 0; i < N; i++) set_req(i, rand_a(), rand_b());
        repeat (N) step();
        repeat (LAT + 2) step();

        // Random traffic with phase-varying request density.
        for (int s = 0; s < 10000; s++) begin
            int dens;
            dens = (s / 700) % 5;
            for (int i = 0; i < N; i++) begin
                if (!pend_v[i] && $urandom_range(0, 3) < dens) set_req(i, rand_a(), rand_b());
            end
            step();
        end
        for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
        repeat (LAT + 3) step();
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
